// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Holds the last result, flags values that do not fit in DIGITS, blanks leading zeros.

module bin2bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin2bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);
    function automatic int digits_for(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 1;
        v = v / 10;
        while (v > 0) begin
            n = n + 1;
            v = v / 10;
        end
        return n;
    endfunction

    // scratch holds every decimal digit BIN_W bits can produce, so nothing is lost
    localparam int SD = (digits_for(BIN_W) > DIGITS) ? digits_for(BIN_W) : DIGITS;
    localparam int SW = 4 * SD;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [BIN_W-1:0]  shreg;
    logic [SW-1:0]     scratch, adj, scratch_nxt;
    logic [CW-1:0]     cnt;
    logic              load, fin, last;
    logic              ovf;
    logic [4*DIGITS-1:0] bcd_res;
    logic [DIGITS-1:0] blank_res;

    for (genvar g = 0; g < SD; g++) begin : g_adj
        bin2bcd_add3 u_add3 (
            .din  (scratch[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign scratch_nxt = {adj[SW-2:0], shreg[BIN_W-1]};
    assign last        = (cnt == CW'(BIN_W - 1));
    assign busy        = (state == SHIFT);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = IDLE;
                    fin       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // The bit leaving the scratch top is always zero since SD covers BIN_W; OR it in anyway.
    always_comb begin
        logic z;
        ovf = adj[SW-1];
        for (int i = DIGITS; i < SD; i++)
            ovf = ovf | (|scratch_nxt[4*i +: 4]);
        bcd_res   = ovf ? {DIGITS{4'h9}} : scratch_nxt[4*DIGITS-1:0];
        blank_res = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z = z & (scratch_nxt[4*i +: 4] == 4'd0);
            blank_res[i] = z & ~ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            bcd      <= '0;
            blank    <= BLANK_RST;
            overflow <= 1'b0;
        end else begin
            done <= fin;
            if (load) begin
                shreg   <= bin;
                scratch <= '0;
                cnt     <= '0;
            end else if (state == SHIFT) begin
                shreg   <= shreg << 1;
                scratch <= scratch_nxt;
                cnt     <= cnt + 1'b1;
            end
            if (fin) begin
                bcd      <= bcd_res;
                blank    <= blank_res;
                overflow <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 4-digit and a 3-digit instance run in lockstep.

module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  bin = '0;
    logic        busy4, done4, ovf4, busy3, done3, ovf3;
    logic [15:0] bcd4;
    logic [11:0] bcd3;
    logic [3:0]  blank4;
    logic [2:0]  blank3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(10), .DIGITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy4), .done(done4), .bcd(bcd4), .blank(blank4), .overflow(ovf4)
    );

    bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy3), .done(done3), .bcd(bcd3), .blank(blank3), .overflow(ovf3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // k = number of edges since the accepting edge E0; returns k when done4 is seen.
    task automatic run(input logic [9:0] v, output int k, output int nbusy,
                       output logic [15:0] mid_bcd);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        nbusy = 0;
        mid_bcd = '0;
        while (!done4 && k < 40) begin
            if (busy4) nbusy++;
            if (k == 5) mid_bcd = bcd4;
            @(negedge clk);
            k++;
        end
    endtask

    int k, nb, ndone, done_k;
    logic [15:0] mid;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_bcd",   32'(bcd4),   32'h0000);
        chk("rst_blank", 32'(blank4), 32'b1110);
        chk("rst_ovf",   32'(ovf4),   32'd0);
        chk("rst_busy",  32'(busy4),  32'd0);
        chk("rst_done",  32'(done4),  32'd0);
        chk("rst_blank3", 32'(blank3), 32'b110);

        run(10'd1023, k, nb, mid);
        chk("1023_lat",   32'(k),      32'd10);
        chk("1023_busy",  32'(nb),     32'd10);
        chk("1023_bsyd",  32'(busy4),  32'd0);
        chk("1023_bcd",   32'(bcd4),   32'h1023);
        chk("1023_blank", 32'(blank4), 32'b0000);
        chk("1023_ovf",   32'(ovf4),   32'd0);
        @(negedge clk);
        chk("1023_pulse", 32'(done4),  32'd0);
        chk("1023_hold",  32'(bcd4),   32'h1023);

        run(10'd7, k, nb, mid);
        chk("7_midhold", 32'(mid),    32'h1023);
        chk("7_bcd",     32'(bcd4),   32'h0007);
        chk("7_blank",   32'(blank4), 32'b1110);
        run(10'd0, k, nb, mid);
        chk("0_bcd",     32'(bcd4),   32'h0000);
        chk("0_blank",   32'(blank4), 32'b1110);

        run(10'd1000, k, nb, mid);
        chk("1000_ovf3",   32'(ovf3),   32'd1);
        chk("1000_bcd3",   32'(bcd3),   32'h999);
        chk("1000_blank3", 32'(blank3), 32'b000);
        chk("1000_bcd4",   32'(bcd4),   32'h1000);
        chk("1000_ovf4",   32'(ovf4),   32'd0);
        run(10'd999, k, nb, mid);
        chk("999_ovf3",    32'(ovf3),   32'd0);
        chk("999_bcd3",    32'(bcd3),   32'h999);
        chk("999_blank3",  32'(blank3), 32'b000);

        // second start at E0+3 with a different bin must be ignored
        @(negedge clk);
        start = 1'b1;
        bin   = 10'd512;
        ndone = 0;
        done_k = -1;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (j == 0) start = 1'b0;
            if (j == 2) begin start = 1'b1; bin = 10'd5; end
            if (j == 3) start = 1'b0;
            if (done4) begin ndone++; done_k = j; end
        end
        chk("512_ndone", 32'(ndone),  32'd1);
        chk("512_donek", 32'(done_k), 32'd10);
        chk("512_bcd",   32'(bcd4),   32'h0512);
        chk("512_blank", 32'(blank4), 32'b1000);

        // reset sampled at E0+4 aborts conversion of 300
        @(negedge clk);
        start = 1'b1;
        bin   = 10'd300;
        ndone = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 0) start = 1'b0;
            if (j == 3) reset = 1'b0;
            if (j == 4) begin
                chk("abort_busy",  32'(busy4),  32'd0);
                chk("abort_bcd",   32'(bcd4),   32'h0000);
                chk("abort_blank", 32'(blank4), 32'b1110);
                reset = 1'b1;
            end
            if (done4) ndone++;
        end
        chk("abort_ndone", 32'(ndone), 32'd0);

        // back-to-back: 300 requested in the done cycle of 42
        run(10'd42, k, nb, mid);
        chk("42_lat",   32'(k),      32'd10);
        chk("42_bcd",   32'(bcd4),   32'h0042);
        chk("42_blank", 32'(blank4), 32'b1100);
        start = 1'b1;
        bin   = 10'd300;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done4 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("300_lat",   32'(k),      32'd10);
        chk("300_bcd",   32'(bcd4),   32'h0300);
        chk("300_blank", 32'(blank4), 32'b1000);
        chk("300_ovf",   32'(ovf4),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
